psram_arbiter: RTL and testbench
================================

# psram_arbiter

Two-port request arbiter that sits directly upstream of the PSRAM `memory` controller. It accepts single-word 16-bit read/write requests from two clients (e.g. CPU port 0, video/DMA port 1), grants them round-robin, and drives the controller's `addr`/`read_strb`/`write_strb`/`data_in` strobe interface. It waits out each controller transaction via `out_ready` and returns read data to the granted client with a one-cycle valid pulse.

## Interface
Parameters:
- `ADDR_W`, 24, word address width, matching controller `addr`
- `DATA_W`, 16, data width, matching controller `data_in`/`data_out`

Ports:
- `clk`  in  1  single system clock; the same clock as the controller; all logic on rising edge
- `rst_n`  in  1  reset: asynchronous assert, active-low
- `req0`, `req1`  in  1  client request; held high with payload stable until matching `ack`
- `we0`, `we1`  in  1  1 = write, 0 = read
- `addr0`, `addr1`  in  ADDR_W  request address
- `wdata0`, `wdata1`  in  DATA_W  write data
- `ack0`, `ack1`  out  1  one-cycle pulse: request accepted and payload latched
- `rvalid0`, `rvalid1`  out  1  one-cycle pulse: `rdata` holds this client's read result
- `rdata`  out  DATA_W  read data, shared by both clients; held until next read completes
- `mem_ready`  in  1  controller `out_ready`
- `mem_addr`  out  ADDR_W  to controller `addr`
- `mem_read_strb`, `mem_write_strb`  out  1  to controller strobes
- `mem_data_in`  out  DATA_W  to controller `data_in`
- `mem_data_out`  in  DATA_W  from controller `data_out`

## Operation
- All outputs registered. Reset values: all strobes, `ack*`, and `rvalid*` 0; `mem_addr`, `mem_data_in`, and `rdata` 0; state IDLE; `last_grant` = 1, so port 0 wins the first tie.
- FSM states: IDLE, ISSUE, GUARD, WAIT.
- IDLE: if `mem_ready`=1 and any `req*`=1, select port:
  - Only one requesting: that port.
  - Both requesting: the port != `last_grant`.
  - Latch `addr`/`wdata`/`we` into `mem_addr`/`mem_data_in`/`op`; record `gnt` and update `last_grant`; go to ISSUE.
  - If `mem_ready`=0, stay in IDLE and issue nothing.
- ISSUE (exactly 1 cycle):
  - `mem_read_strb`=!op or `mem_write_strb`=op; never both.
  - `ack[gnt]`=1. Go to GUARD.
- GUARD (exactly 1 cycle): strobes 0; `mem_ready` is ignored, since the controller's registered ready has not yet fallen. Go to WAIT.
- WAIT: stay until `mem_ready`=1. On that cycle:
  - Read: `rdata` <= `mem_data_out` and `rvalid[gnt]` pulses next cycle.
  - Write: no response pulse.
  - Go to IDLE.
- `mem_addr` and `mem_data_in` hold their latched values from ISSUE through WAIT; they change only on the next grant.
- A request arriving while busy is not acked until a later IDLE grant. Clients must not deassert `req` before `ack`; deassertion before grant simply withdraws the request.
- No queuing: at most one outstanding transaction.
- Reset mid-transaction: all outputs return to reset values immediately and the FSM goes to IDLE. The controller is not reset by this block; the next grant waits for `mem_ready`=1 as normal, so the in-flight controller operation completes unobserved and no `rvalid` is produced for it.

## Timing
- Cycle 0: IDLE sees `mem_ready`=1 and `req`. Cycle 1: ISSUE, strobe and `ack` high. Cycle 2: GUARD. Cycle ≥3: WAIT.
- Completion cycle C (first WAIT cycle with `mem_ready`=1): for a read, `rvalid`/`rdata` appear at C+1. FSM is in IDLE at C+1 and may grant again at C+1, with the next strobe at C+2.
- Minimum issue-to-issue spacing: 4 cycles (controller permitting).
- `rdata` is valid in the `rvalid` cycle and stays stable until the next read completes.
- Round-robin fairness: with both ports continuously requesting, grants strictly alternate 0,1,0,1…

## Test plan
- Single read, port 0, addr 0x000123: memory model returns 0xBEEF after `mem_ready` is low 20 cycles → `mem_read_strb` high exactly 1 cycle with `mem_addr`=0x000123; `ack0` in the same cycle; `rvalid0`=1 with `rdata`=0xBEEF one cycle after `mem_ready` rises; `rvalid1` stays 0.
- Single write, port 1, addr 0xFFFFFF, data 0x5A5A → `mem_write_strb` 1 cycle with `mem_data_in`=0x5A5A; `ack1` pulse; no `rvalid`; FSM back in IDLE after `mem_ready` returns.
- Both ports continuously requesting from reset (port 0 reads, port 1 writes) for 6 transactions → grant order 0,1,0,1,0,1; each `ack` paired with the correct address and data.
- Request asserted while `mem_ready`=0 (controller still initializing, held low 200 cycles) → no strobe or `ack` until the cycle after `mem_ready` rises; then the normal 1-cycle strobe.
- `rst_n` pulsed low during WAIT of a read → `rvalid0` never asserted for that read; all outputs at reset values while `rst_n` is low; a new port 1 read after reset completes normally with correct data.
- Back-to-back reads, port 0, with `mem_ready` rising the cycle after GUARD → second strobe exactly 4 cycles after the first; `rdata` updates to the second value only at the second `rvalid0`.

Source files
------------

// File: rtl/psram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : psram_arbiter
//  Description : Two-client round-robin arbiter feeding the PSRAM controller
//                strobe interface. One outstanding transaction at a time;
//                read data is returned with a one-cycle valid pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module psram_arbiter #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    // client port 0
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic              rvalid0,
    // client port 1
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic              rvalid1,
    // shared read data
    output logic [DATA_W-1:0] rdata,
    // controller side
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read_strb,
    output logic              mem_write_strb,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    // GUARD exists because the controller's ready is registered and only
    // falls one cycle after it sees a strobe.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GUARD = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                op_q, op_d;                 // 1 = write
    logic                gnt_q, gnt_d;               // port owning the transaction
    logic                last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_data_in_q, mem_data_in_d;
    logic                rd_strb_q, rd_strb_d;
    logic                wr_strb_q, wr_strb_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic                rvalid0_q, rvalid0_d;
    logic                rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                w_sel;   // port chosen in IDLE
    logic                w_sel_we;

    // Round-robin pick: a lone requester wins, a tie goes to the port not served last
    always_comb begin
        w_sel = 1'b0;
        if (req0 && req1) begin
            w_sel = ~last_grant_q;
        end else begin
            w_sel = req1;
        end
        w_sel_we = w_sel ? we1 : we0;
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        gnt_d         = gnt_q;
        last_grant_d  = last_grant_q;
        mem_addr_d    = mem_addr_q;
        mem_data_in_d = mem_data_in_q;
        rdata_d       = rdata_q;
        rd_strb_d     = 1'b0;
        wr_strb_d     = 1'b0;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;
        rvalid0_d     = 1'b0;
        rvalid1_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_ready && (req0 || req1)) begin
                    mem_addr_d    = w_sel ? addr1 : addr0;
                    mem_data_in_d = w_sel ? wdata1 : wdata0;
                    op_d          = w_sel_we;
                    gnt_d         = w_sel;
                    last_grant_d  = w_sel;
                    // strobe and ack become visible during ISSUE
                    rd_strb_d     = ~w_sel_we;
                    wr_strb_d     = w_sel_we;
                    ack0_d        = ~w_sel;
                    ack1_d        = w_sel;
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_GUARD;
            end
            ST_GUARD: begin
                // controller ready is stale here, so it is deliberately not looked at
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    if (!op_q) begin
                        rdata_d   = mem_data_out;
                        rvalid0_d = ~gnt_q;
                        rvalid1_d = gnt_q;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; async reset abandons any in-flight transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            op_q          <= 1'b0;
            gnt_q         <= 1'b0;
            last_grant_q  <= 1'b1;
            mem_addr_q    <= '0;
            mem_data_in_q <= '0;
            rdata_q       <= '0;
            rd_strb_q     <= 1'b0;
            wr_strb_q     <= 1'b0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            rvalid0_q     <= 1'b0;
            rvalid1_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            gnt_q         <= gnt_d;
            last_grant_q  <= last_grant_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_in_q <= mem_data_in_d;
            rdata_q       <= rdata_d;
            rd_strb_q     <= rd_strb_d;
            wr_strb_q     <= wr_strb_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            rvalid0_q     <= rvalid0_d;
            rvalid1_q     <= rvalid1_d;
        end
    end

    assign mem_addr       = mem_addr_q;
    assign mem_data_in    = mem_data_in_q;
    assign mem_read_strb  = rd_strb_q;
    assign mem_write_strb = wr_strb_q;
    assign ack0           = ack0_q;
    assign ack1           = ack1_q;
    assign rvalid0        = rvalid0_q;
    assign rvalid1        = rvalid1_q;
    assign rdata          = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_psram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psram_arbiter
//  Description : Self-checking bench for psram_arbiter with a behavioural
//                PSRAM controller model and per-port scoreboards.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_psram_arbiter;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
    logic              ack0, ack1, rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read_strb, mem_write_strb;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out = '0;

    psram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rvalid1(rvalid1),
        .rdata(rdata), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_read_strb(mem_read_strb), .mem_write_strb(mem_write_strb),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // ---------------- controller model ----------------
    logic              rdy_q = 1'b1;
    logic              hold = 1'b0;      // models controller still initialising
    int                lat = 20;         // cycles ready stays low per transaction
    int                cnt = 0;
    int                pend = 0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];

    assign mem_ready = rdy_q & ~hold;

    function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
        return mem.exists(a) ? mem[a] : 16'h0BAD;
    endfunction

    initial forever begin
        @(posedge clk);
        if (mem_read_strb || mem_write_strb) begin
            pend   <= 1;
            m_addr <= mem_addr;
            if (mem_write_strb) mem[mem_addr] = mem_data_in;
            else if (lat == 0) mem_data_out <= mem_rd(mem_addr);
        end else if (pend != 0) begin
            pend <= 0;
            if (lat > 0) begin
                rdy_q        <= 1'b0;
                cnt          <= lat;
                mem_data_out <= 16'hDEAD;
            end
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                rdy_q        <= 1'b1;
                mem_data_out <= mem_rd(m_addr);
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    req_t              q_ack0[$], q_ack1[$];
    logic [DATA_W-1:0] q_rd0[$], q_rd1[$];
    int                grant_log[$];
    int                cyc = 0, rise_cyc = -1, strobe_cyc = -1, strobe_prev_cyc = -1;
    int                rv0_cyc = -1, rv1_cyc = -1, ack_total = 0, n_strobe = 0;
    logic              prev_ready = 1'b1;
    logic [DATA_W-1:0] rdata_exp = '0;
    logic [ADDR_W-1:0] addr_hold = '0;
    logic [DATA_W-1:0] din_hold = '0;

    initial forever begin
        req_t              e;
        logic              a;
        logic              rv;
        logic [DATA_W-1:0] x;
        @(negedge clk);
        cyc++;
        if (mem_ready && !prev_ready) rise_cyc = cyc;
        prev_ready = mem_ready;
        if (!rst_n) begin
            rdata_exp = '0;
            addr_hold = '0;
            din_hold  = '0;
        end else begin
            checks++;
            if (((mem_read_strb | mem_write_strb) !== (ack0 | ack1)) ||
                (mem_read_strb & mem_write_strb) || (ack0 & ack1)) begin
                failures++;
                $display("FAIL strobe_ack_pairing cyc=%0d rd=%b wr=%b ack0=%b ack1=%b required one strobe with exactly one ack",
                         cyc, mem_read_strb, mem_write_strb, ack0, ack1);
            end
            if (mem_read_strb | mem_write_strb) begin
                strobe_prev_cyc = strobe_cyc;
                strobe_cyc      = cyc;
                n_strobe++;
            end
            if (ack0 | ack1) begin
                ack_total++;
                grant_log.push_back(ack1 ? 1 : 0);
                addr_hold = mem_addr;
                din_hold  = mem_data_in;
            end else begin
                checks++;
                if (mem_addr !== addr_hold || mem_data_in !== din_hold) begin
                    failures++;
                    $display("FAIL payload_hold cyc=%0d addr=%h din=%h required addr=%h din=%h",
                             cyc, mem_addr, mem_data_in, addr_hold, din_hold);
                end
            end
            for (int p = 0; p < 2; p++) begin
                a = (p == 0) ? ack0 : ack1;
                if (a) begin
                    checks++;
                    if ((p == 0 && q_ack0.size() == 0) || (p == 1 && q_ack1.size() == 0)) begin
                        failures++;
                        $display("FAIL unexpected_ack port%0d cyc=%0d addr=%h required no ack", p, cyc, mem_addr);
                    end else begin
                        e = (p == 0) ? q_ack0.pop_front() : q_ack1.pop_front();
                        if (mem_addr !== e.addr || mem_read_strb !== !e.we || mem_write_strb !== e.we ||
                            (e.we && mem_data_in !== e.wdata)) begin
                            failures++;
                            $display("FAIL ack_payload port%0d cyc=%0d addr=%h rd=%b wr=%b din=%h required addr=%h we=%b din=%h",
                                     p, cyc, mem_addr, mem_read_strb, mem_write_strb, mem_data_in, e.addr, e.we, e.wdata);
                        end
                    end
                end
                rv = (p == 0) ? rvalid0 : rvalid1;
                if (rv) begin
                    checks++;
                    if ((p == 0 && q_rd0.size() == 0) || (p == 1 && q_rd1.size() == 0)) begin
                        failures++;
                        $display("FAIL unexpected_rvalid port%0d cyc=%0d rdata=%h required no rvalid", p, cyc, rdata);
                    end else begin
                        x = (p == 0) ? q_rd0.pop_front() : q_rd1.pop_front();
                        if (rdata !== x || (rvalid0 & rvalid1)) begin
                            failures++;
                            $display("FAIL read_data port%0d cyc=%0d rdata=%h required %h", p, cyc, rdata, x);
                        end
                        rdata_exp = x;
                    end
                    if (p == 0) rv0_cyc = cyc; else rv1_cyc = cyc;
                end
            end
            if (!(rvalid0 | rvalid1)) begin
                checks++;
                if (rdata !== rdata_exp) begin
                    failures++;
                    $display("FAIL rdata_hold cyc=%0d rdata=%h required %h", cyc, rdata, rdata_exp);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Presents one request, waits for its ack, then drops req unless keep is set.
    task automatic client(input int p, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] rexp,
                          input bit exp_rv, input bit keep, output int start_c, output int ack_c);
        req_t e;
        bit   got;
        e       = '{we: we, addr: a, wdata: d};
        start_c = cyc;
        ack_c   = -1;
        got     = 1'b0;
        if (p == 0) begin
            q_ack0.push_back(e);
            if (!we && exp_rv) q_rd0.push_back(rexp);
            we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1;
        end else begin
            q_ack1.push_back(e);
            if (!we && exp_rv) q_rd1.push_back(rexp);
            we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1;
        end
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            #1;
            got = (p == 0) ? ack0 : ack1;
        end
        ack_c = cyc;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL ack_timeout port%0d addr=%h no ack within 2000 cycles, required ack", p, a);
        end
        @(posedge clk);
        #1;
        if (!keep) begin
            if (p == 0) req0 = 1'b0; else req1 = 1'b0;
        end
    endtask

    task automatic settle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            #1;
            done = (pend == 0) && (cnt == 0) && mem_ready && (q_rd0.size() == 0) && (q_rd1.size() == 0);
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL settle_timeout pending rd0=%0d rd1=%0d required all complete", q_rd0.size(), q_rd1.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic check_outputs_zero(input string tag);
        checks++;
        if ({mem_read_strb, mem_write_strb, ack0, ack1, rvalid0, rvalid1} !== 6'b0) begin
            failures++;
            $display("FAIL %s_pulses strb/ack/rvalid=%b required 000000", tag,
                     {mem_read_strb, mem_write_strb, ack0, ack1, rvalid0, rvalid1});
        end
        checks++;
        if (mem_addr !== '0 || mem_data_in !== '0 || rdata !== '0) begin
            failures++;
            $display("FAIL %s_data addr=%h din=%h rdata=%h required 0", tag, mem_addr, mem_data_in, rdata);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1 check_outputs_zero("reset_asserted");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_outputs_zero("reset_idle");
    endtask

    task automatic test_single_read();
        int s, a;
        lat = 20;
        mem[24'h000123] = 16'hBEEF;
        client(0, 1'b0, 24'h000123, 16'h0, 16'hBEEF, 1'b1, 1'b0, s, a);
        checks++;
        if (a != s + 2) begin
            failures++;
            $display("FAIL read_ack_latency ack_cyc=%0d required %0d", a, s + 2);
        end
        settle();
        checks++;
        if (rv0_cyc != rise_cyc + 1) begin
            failures++;
            $display("FAIL read_rvalid_timing rvalid_cyc=%0d required %0d", rv0_cyc, rise_cyc + 1);
        end
    endtask

    task automatic test_single_write();
        int s, a;
        lat = 20;
        client(1, 1'b1, 24'hFFFFFF, 16'h5A5A, 16'h0, 1'b0, 1'b0, s, a);
        settle();
        checks++;
        if (mem_rd(24'hFFFFFF) !== 16'h5A5A) begin
            failures++;
            $display("FAIL write_landed mem=%h required 5a5a", mem_rd(24'hFFFFFF));
        end
        // arbiter must be back in IDLE and grant immediately
        client(0, 1'b0, 24'hFFFFFF, 16'h0, 16'h5A5A, 1'b1, 1'b0, s, a);
        checks++;
        if (a != s + 2) begin
            failures++;
            $display("FAIL idle_after_write ack_cyc=%0d required %0d", a, s + 2);
        end
        settle();
    endtask

    task automatic test_round_robin();
        int exp_g;
        do_reset();
        lat = 4;
        for (int i = 0; i < 3; i++) mem[24'h000010 + i] = 16'h1000 + 16'(i);
        grant_log.delete();
        fork
            begin : b_port0
                int s0, a0;
                for (int i = 0; i < 3; i++)
                    client(0, 1'b0, 24'h000010 + i, 16'h0, 16'h1000 + 16'(i), 1'b1, (i < 2), s0, a0);
            end
            begin : b_port1
                int s1, a1;
                for (int i = 0; i < 3; i++)
                    client(1, 1'b1, 24'h000020 + i, 16'h2000 + 16'(i), 16'h0, 1'b0, (i < 2), s1, a1);
            end
        join
        settle();
        checks++;
        if (grant_log.size() != 6) begin
            failures++;
            $display("FAIL rr_grant_count got=%0d required 6", grant_log.size());
        end
        for (int i = 0; i < grant_log.size() && i < 6; i++) begin
            exp_g = i % 2;
            checks++;
            if (grant_log[i] != exp_g) begin
                failures++;
                $display("FAIL rr_order idx=%0d port=%0d required %0d", i, grant_log[i], exp_g);
            end
        end
    endtask

    task automatic test_init_hold();
        int s, a, base_ack, base_strb;
        lat = 6;
        mem[24'h000ABC] = 16'hABCD;
        base_ack  = ack_total;
        base_strb = n_strobe;
        hold      = 1'b1;
        fork
            client(0, 1'b0, 24'h000ABC, 16'h0, 16'hABCD, 1'b1, 1'b0, s, a);
            begin
                repeat (200) @(posedge clk);
                #1;
                checks++;
                if (ack_total != base_ack || n_strobe != base_strb) begin
                    failures++;
                    $display("FAIL init_no_issue acks=%0d strobes=%0d required %0d/%0d",
                             ack_total - base_ack, n_strobe - base_strb, 0, 0);
                end
                hold = 1'b0;
            end
        join
        checks++;
        if (a != rise_cyc + 1) begin
            failures++;
            $display("FAIL init_ack_timing ack_cyc=%0d required %0d", a, rise_cyc + 1);
        end
        settle();
    endtask

    task automatic test_reset_mid_read();
        int s, a;
        lat = 20;
        mem[24'h000321] = 16'h3210;
        mem[24'h000777] = 16'h7777;
        client(0, 1'b0, 24'h000321, 16'h0, 16'h0, 1'b0, 1'b0, s, a);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_outputs_zero("reset_mid_read");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        client(1, 1'b0, 24'h000777, 16'h0, 16'h7777, 1'b1, 1'b0, s, a);
        checks++;
        if (a != rise_cyc + 1) begin
            failures++;
            $display("FAIL post_reset_ack ack_cyc=%0d required %0d", a, rise_cyc + 1);
        end
        settle();
        checks++;
        if (rv1_cyc != rise_cyc + 1) begin
            failures++;
            $display("FAIL post_reset_rvalid rvalid_cyc=%0d required %0d", rv1_cyc, rise_cyc + 1);
        end
    endtask

    task automatic test_back_to_back();
        int s, a;
        lat = 0;
        mem[24'h000400] = 16'h4444;
        mem[24'h000401] = 16'h5555;
        client(0, 1'b0, 24'h000400, 16'h0, 16'h4444, 1'b1, 1'b1, s, a);
        client(0, 1'b0, 24'h000401, 16'h0, 16'h5555, 1'b1, 1'b0, s, a);
        settle();
        checks++;
        if (strobe_cyc - strobe_prev_cyc != 4) begin
            failures++;
            $display("FAIL b2b_spacing gap=%0d required 4", strobe_cyc - strobe_prev_cyc);
        end
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL global_timeout simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_round_robin();
        test_init_hold();
        test_reset_mid_read();
        test_back_to_back();
        checks++;
        if (q_ack0.size() + q_ack1.size() + q_rd0.size() + q_rd1.size() != 0) begin
            failures++;
            $display("FAIL leftover_expectations ack0=%0d ack1=%0d rd0=%0d rd1=%0d required 0",
                     q_ack0.size(), q_ack1.size(), q_rd0.size(), q_rd1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
